// File: rtl/mdu_pkg.sv
// Shared types and constants for the iterative divider (mdu_div).
package mdu_pkg;

    // Width of the step counter; covers 32 iterations plus headroom.
    localparam int unsigned DIV_CNT_W = 6;

    typedef enum logic [1:0] {
        DIV  = 2'b00,
        DIVU = 2'b01,
        REM  = 2'b10,
        REMU = 2'b11
    } mdu_op_t;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } div_state_t;

    // DIV and REM interpret their operands as two's complement.
    function automatic logic op_is_signed(input mdu_op_t op);
        return (op == DIV) || (op == REM);
    endfunction

    // REM and REMU return the remainder; the other two return the quotient.
    function automatic logic op_is_rem(input mdu_op_t op);
        return (op == REM) || (op == REMU);
    endfunction

endpackage

// File: rtl/div_step.sv
// Combinational single restoring-division step: shift {rem, quo} left by one,
// then try to subtract the divisor from the partial remainder.
module div_step #(
    parameter int unsigned WIDTH = 32
) (
    input  logic [WIDTH:0]   rem_i,
    input  logic [WIDTH-1:0] quo_i,
    input  logic [WIDTH-1:0] divisor_i,
    output logic [WIDTH:0]   rem_o,
    output logic [WIDTH-1:0] quo_o
);

    // One extra bit on top so the borrow of the trial subtract is explicit.
    logic [WIDTH+1:0] shifted;
    logic [WIDTH+1:0] trial;

    assign shifted = {rem_i, quo_i[WIDTH-1]};
    assign trial   = shifted - {2'b00, divisor_i};

    // Keep the difference and set the quotient bit only when it did not borrow.
    always_comb begin
        if (!trial[WIDTH+1]) begin
            rem_o = trial[WIDTH:0];
            quo_o = {quo_i[WIDTH-2:0], 1'b1};
        end else begin
            rem_o = shifted[WIDTH:0];
            quo_o = {quo_i[WIDTH-2:0], 1'b0};
        end
    end

endmodule

// File: rtl/mdu_div.sv
// Iterative restoring divider for RV32M DIV/DIVU/REM/REMU, one quotient bit
// per cycle over a valid/ready handshake.
// Optional feature: define MDU_DIV_EARLY_OUT_EN to send divide-by-zero and
// signed overflow straight from IDLE to DONE instead of running all steps.
module mdu_div
    import mdu_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [1:0]            in_op,
    input  logic [DATA_WIDTH-1:0] in_a,
    input  logic [DATA_WIDTH-1:0] in_b,
    input  logic                  flush,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_result
);

    localparam logic [DIV_CNT_W-1:0] LastCnt = DIV_CNT_W'(DATA_WIDTH - 1);
    localparam logic [DATA_WIDTH-1:0] MinNeg = {1'b1, {(DATA_WIDTH-1){1'b0}}};

    div_state_t            state_q, state_d;
    mdu_op_t               op_q, op_d;
    logic [DATA_WIDTH:0]   rem_q, rem_d;
    logic [DATA_WIDTH-1:0] quo_q, quo_d;
    logic [DATA_WIDTH-1:0] dvsr_q, dvsr_d;
    logic [DATA_WIDTH-1:0] a_q, a_d;
    logic [DIV_CNT_W-1:0]  cnt_q, cnt_d;
    logic                  q_neg_q, q_neg_d;
    logic                  r_neg_q, r_neg_d;
    logic                  zero_q, zero_d;
    logic                  ovf_q, ovf_d;

    mdu_op_t               in_op_e;
    logic                  in_signed;
    logic [DATA_WIDTH-1:0] a_abs;
    logic [DATA_WIDTH-1:0] b_abs;
    logic                  in_zero;
    logic                  in_ovf;
    logic                  accept;
    logic [DATA_WIDTH:0]   step_rem;
    logic [DATA_WIDTH-1:0] step_quo;
    logic [DATA_WIDTH-1:0] quo_res;
    logic [DATA_WIDTH-1:0] rem_res;

    div_step #(
        .WIDTH (DATA_WIDTH)
    ) u_div_step (
        .rem_i     (rem_q),
        .quo_i     (quo_q),
        .divisor_i (dvsr_q),
        .rem_o     (step_rem),
        .quo_o     (step_quo)
    );

    // Operand preparation: magnitudes and special-case detection at accept.
    always_comb begin
        in_op_e   = mdu_op_t'(in_op);
        in_signed = op_is_signed(in_op_e);
        a_abs     = (in_signed && in_a[DATA_WIDTH-1]) ? -in_a : in_a;
        b_abs     = (in_signed && in_b[DATA_WIDTH-1]) ? -in_b : in_b;
        in_zero   = (in_b == '0);
        in_ovf    = in_signed && (in_a == MinNeg) && (in_b == '1);
        // A flush in the same cycle wins over the accept.
        accept    = in_valid && in_ready && !flush;
    end

    // Next-state logic for the FSM, counter and datapath registers.
    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        rem_d   = rem_q;
        quo_d   = quo_q;
        dvsr_d  = dvsr_q;
        a_d     = a_q;
        cnt_d   = cnt_q;
        q_neg_d = q_neg_q;
        r_neg_d = r_neg_q;
        zero_d  = zero_q;
        ovf_d   = ovf_q;

        unique case (state_q)
            IDLE: begin
                if (accept) begin
`ifdef MDU_DIV_EARLY_OUT_EN
                    state_d = (in_zero || in_ovf) ? DONE : CALC;
`else
                    state_d = CALC;
`endif
                    op_d    = in_op_e;
                    rem_d   = '0;
                    quo_d   = a_abs;
                    dvsr_d  = b_abs;
                    a_d     = in_a;
                    cnt_d   = '0;
                    q_neg_d = in_signed && (in_a[DATA_WIDTH-1] ^ in_b[DATA_WIDTH-1]);
                    r_neg_d = in_signed && in_a[DATA_WIDTH-1];
                    zero_d  = in_zero;
                    ovf_d   = in_ovf;
                end
            end
            CALC: begin
                rem_d = step_rem;
                quo_d = step_quo;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LastCnt) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (flush) begin
            state_d = IDLE;
        end
    end

    // Result formation: sign fix-up, then RISC-V special-case override.
    always_comb begin
        quo_res = q_neg_q ? -quo_q : quo_q;
        rem_res = r_neg_q ? -rem_q[DATA_WIDTH-1:0] : rem_q[DATA_WIDTH-1:0];
        if (zero_q) begin
            quo_res = '1;
            rem_res = a_q;
        end else if (ovf_q) begin
            quo_res = MinNeg;
            rem_res = '0;
        end
        in_ready   = (state_q == IDLE);
        out_valid  = (state_q == DONE);
        out_result = '0;
        if (state_q == DONE) begin
            out_result = op_is_rem(op_q) ? rem_res : quo_res;
        end
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            op_q    <= DIV;
            rem_q   <= '0;
            quo_q   <= '0;
            dvsr_q  <= '0;
            a_q     <= '0;
            cnt_q   <= '0;
            q_neg_q <= 1'b0;
            r_neg_q <= 1'b0;
            zero_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            rem_q   <= rem_d;
            quo_q   <= quo_d;
            dvsr_q  <= dvsr_d;
            a_q     <= a_d;
            cnt_q   <= cnt_d;
            q_neg_q <= q_neg_d;
            r_neg_q <= r_neg_d;
            zero_q  <= zero_d;
            ovf_q   <= ovf_d;
        end
    end

endmodule

// File: tb/tb_mdu_div.sv
// Self-checking bench for mdu_div: directed vector table, randomized ops
// against an arithmetic reference model, and handshake/flush/reset sequences.
module tb_mdu_div;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  in_op;
    logic [31:0] in_a;
    logic [31:0] in_b;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_result;

    int checks   = 0;
    int failures = 0;

    mdu_div #(
        .DATA_WIDTH (32)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_op      (in_op),
        .in_a       (in_a),
        .in_b       (in_b),
        .flush      (flush),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs[16];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // RISC-V M-extension semantics from plain integer arithmetic.
    function automatic logic [31:0] ref_model(input logic [1:0] op, input logic [31:0] a,
                                              input logic [31:0] b);
        int sa;
        int sb;
        sa = a;
        sb = b;
        if (b == 32'd0) return op[1] ? a : 32'hFFFF_FFFF;
        case (op)
            2'd0: return (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) ? 32'h8000_0000
                                                                     : 32'(sa / sb);
            2'd1: return a / b;
            2'd2: return (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) ? 32'd0 : 32'(sa % sb);
            default: return a % b;
        endcase
    endfunction

    function automatic int exp_lat(input logic [1:0] op, input logic [31:0] a,
                                   input logic [31:0] b);
`ifdef MDU_DIV_EARLY_OUT_EN
        if (b == 32'd0) return 1;
        if (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
        return 33;
`else
        if (op == 2'd0 && a == 32'd0 && b == 32'd0) return 33;
        return 33;
`endif
    endfunction

    task automatic wait_ready();
        int g;
        g = 0;
        while (!in_ready && g < 100) begin
            @(posedge clk);
            #1;
            g++;
        end
        if (!in_ready) check("wait_in_ready", {31'd0, in_ready}, 32'd1);
    endtask

    // Issue one op, measure cycles to out_valid, hold it for 'hold' cycles, consume.
    task automatic do_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                         input int hold, output logic [31:0] res, output int lat);
        wait_ready();
        in_valid = 1'b1;
        in_op    = op;
        in_a     = a;
        in_b     = b;
        lat      = 0;
        while (lat < 100) begin
            @(posedge clk);
            #1;
            lat++;
            in_valid = 1'b0;
            if (out_valid) break;
        end
        res = out_result;
        for (int i = 0; i < hold; i++) begin
            @(posedge clk);
            #1;
            check("hold_out_valid", {31'd0, out_valid}, 32'd1);
            check("hold_out_result", out_result, res);
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check("consume_in_ready", {31'd0, in_ready}, 32'd1);
        check("consume_out_valid", {31'd0, out_valid}, 32'd0);
    endtask

    initial begin
        logic [31:0] res;
        logic [31:0] a;
        logic [31:0] b;
        logic [1:0]  op;
        int          lat;
        int          cyc;
        bit          seen;

        vecs[0]  = '{2'd1, 32'd100,         32'd7,           32'd14};
        vecs[1]  = '{2'd3, 32'd100,         32'd7,           32'd2};
        vecs[2]  = '{2'd0, 32'hFFFF_FFF9,   32'd2,           32'hFFFF_FFFD};
        vecs[3]  = '{2'd2, 32'hFFFF_FFF9,   32'd2,           32'hFFFF_FFFF};
        vecs[4]  = '{2'd2, 32'd7,           32'hFFFF_FFFE,   32'd1};
        vecs[5]  = '{2'd0, 32'd5,           32'd0,           32'hFFFF_FFFF};
        vecs[6]  = '{2'd2, 32'd5,           32'd0,           32'd5};
        vecs[7]  = '{2'd0, 32'h8000_0000,   32'hFFFF_FFFF,   32'h8000_0000};
        vecs[8]  = '{2'd2, 32'h8000_0000,   32'hFFFF_FFFF,   32'd0};
        vecs[9]  = '{2'd1, 32'hFFFF_FFFF,   32'd1,           32'hFFFF_FFFF};
        vecs[10] = '{2'd3, 32'hFFFF_FFFF,   32'd0,           32'hFFFF_FFFF};
        vecs[11] = '{2'd0, 32'hFFFF_FFFF,   32'd0,           32'hFFFF_FFFF};
        vecs[12] = '{2'd2, 32'hFFFF_FFF9,   32'd0,           32'hFFFF_FFF9};
        vecs[13] = '{2'd1, 32'h8000_0000,   32'hFFFF_FFFF,   32'd0};
        vecs[14] = '{2'd3, 32'h8000_0000,   32'hFFFF_FFFF,   32'h8000_0000};
        vecs[15] = '{2'd0, 32'h8000_0000,   32'd1,           32'h8000_0000};

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_op     = 2'd0;
        in_a      = 32'd0;
        in_b      = 32'd0;
        flush     = 1'b0;
        out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_in_ready", {31'd0, in_ready}, 32'd1);
        check("reset_out_valid", {31'd0, out_valid}, 32'd0);
        check("reset_out_result", out_result, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Directed vectors with exact latency.
        for (int i = 0; i < 16; i++) begin
            do_op(vecs[i].op, vecs[i].a, vecs[i].b, 0, res, lat);
            check($sformatf("vec%0d_result", i), res, vecs[i].exp);
            check($sformatf("vec%0d_latency", i), 32'(lat),
                  32'(exp_lat(vecs[i].op, vecs[i].a, vecs[i].b)));
        end

        // Result held stable while out_ready stays low for 10 cycles.
        do_op(2'd1, 32'd100, 32'd7, 10, res, lat);
        check("hold_seq_result", res, 32'd14);

        // in_valid pulses during CALC are ignored.
        wait_ready();
        in_valid = 1'b1;
        in_op    = 2'd1;
        in_a     = 32'd1000;
        in_b     = 32'd3;
        cyc      = 0;
        while (cyc < 100) begin
            @(posedge clk);
            #1;
            cyc++;
            if (out_valid) break;
            check("calc_in_ready_low", {31'd0, in_ready}, 32'd0);
            in_valid = (cyc == 5 || cyc == 6);
            in_a     = 32'd77;
            in_b     = 32'd5;
        end
        in_valid = 1'b0;
        check("pulse_latency", 32'(cyc), 32'd33);
        check("pulse_result", out_result, 32'd333);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check("pulse_in_ready_after", {31'd0, in_ready}, 32'd1);

        // Flush at CALC step 15: back to IDLE, no result ever appears.
        in_valid = 1'b1;
        in_op    = 2'd0;
        in_a     = 32'd12345;
        in_b     = 32'd67;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (14) @(posedge clk);
        #1;
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        check("flush_in_ready", {31'd0, in_ready}, 32'd1);
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            if (out_valid) seen = 1'b1;
        end
        check("flush_no_out_valid", {31'd0, seen}, 32'd0);

        // Flush wins over a same-cycle accept.
        in_valid = 1'b1;
        flush    = 1'b1;
        in_op    = 2'd1;
        in_a     = 32'd9;
        in_b     = 32'd3;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        flush    = 1'b0;
        check("flush_prio_in_ready", {31'd0, in_ready}, 32'd1);
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            if (out_valid) seen = 1'b1;
        end
        check("flush_prio_no_result", {31'd0, seen}, 32'd0);

        // Flush in DONE drops out_valid.
        in_valid = 1'b1;
        in_op    = 2'd1;
        in_a     = 32'd50;
        in_b     = 32'd5;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (40) @(posedge clk);
        #1;
        check("done_before_flush", {31'd0, out_valid}, 32'd1);
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        check("done_flush_out_valid", {31'd0, out_valid}, 32'd0);
        check("done_flush_in_ready", {31'd0, in_ready}, 32'd1);

        // Asynchronous reset mid-CALC.
        in_valid = 1'b1;
        in_op    = 2'd0;
        in_a     = 32'd999;
        in_b     = 32'd4;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (9) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("areset_in_ready", {31'd0, in_ready}, 32'd1);
        check("areset_out_valid", {31'd0, out_valid}, 32'd0);
        check("areset_out_result", out_result, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        do_op(2'd0, 32'd999, 32'd4, 0, res, lat);
        check("after_reset_result", res, 32'd249);

        // Randomized ops against the reference model.
        for (int i = 0; i < 60; i++) begin
            op = 2'($urandom_range(0, 3));
            a  = ($urandom_range(0, 7) == 0) ? 32'h8000_0000 : $urandom;
            case ($urandom_range(0, 7))
                0:       b = 32'd0;
                1:       b = 32'hFFFF_FFFF;
                2:       b = 32'($urandom_range(1, 15));
                3:       b = -32'($urandom_range(1, 15));
                default: b = $urandom >> $urandom_range(0, 28);
            endcase
            do_op(op, a, b, $urandom_range(0, 2), res, lat);
            check($sformatf("rand%0d_op%0d_%h_%h", i, op, a, b), res, ref_model(op, a, b));
            check($sformatf("rand%0d_latency", i), 32'(lat), 32'(exp_lat(op, a, b)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mdu_div.md
# mdu_div

Iterative restoring divider for the NPC execute stage. It implements RV32M DIV/DIVU/REM/REMU over a valid/ready handshake and produces one quotient bit per cycle. It sits beside the 32-bit adder in the EXU. The EXU steers M-extension divide ops here instead of to the adder, and it muxes `out_result` into the writeback path.

## Interface
- `DATA_WIDTH`, 32, operand/result width; the iteration count equals DATA_WIDTH.
- `clk`  in  1  rising-edge clock
- `rst_n`  in  1  asynchronous, active-low reset
- `in_valid`  in  1  operands and op are valid
- `in_ready`  out  1  divider is idle and can accept; equals (state==IDLE)
- `in_op`  in  2  00 DIV, 01 DIVU, 10 REM, 11 REMU
- `in_a`  in  DATA_WIDTH  dividend (rs1)
- `in_b`  in  DATA_WIDTH  divisor (rs2)
- `flush`  in  1  synchronous abort; pipeline redirect
- `out_valid`  out  1  result is valid; held until consumed
- `out_ready`  in  1  consumer takes the result
- `out_result`  out  DATA_WIDTH  quotient or remainder per the latched op

## Operation
- States: IDLE, CALC, DONE.
- IDLE → CALC on `in_valid && in_ready`. On that transition the block latches:
  - the op;
  - |a| and |b| (absolute values for signed ops, raw values for unsigned);
  - `q_neg` = a[31]^b[31] (signed ops only);
  - `r_neg` = a[31] (signed ops only);
  - it clears the 33-bit partial remainder and the 6-bit count.
- CALC step, one per cycle:
  - shift {rem, quo} left by 1;
  - compute trial = rem[32:0] − {1'b0, |b|} as a 33-bit subtract;
  - if trial is non-negative, rem = trial and the quotient LSB = 1, else the quotient LSB = 0;
  - the count increments each step;
  - after the 32nd step the state moves to DONE.
- DONE: `out_valid`=1. `out_result` is formed combinationally from the registers:
  - quotient negated if `q_neg`;
  - remainder negated if `r_neg`.
- DONE → IDLE on `out_ready`. `in_ready` rises the following cycle; there is no same-cycle re-accept.
- Special cases (RISC-V mandated, no trap):
  - b==0: quotient = all ones; remainder = a.
  - Signed a=0x8000_0000 with b=0xFFFF_FFFF: quotient = 0x8000_0000; remainder = 0.
  - Both cases are detected at accept and latched as `special` flags.
- `flush` in any state → IDLE next cycle, and `out_valid` drops. `flush` takes priority over an accept or `out_ready` in the same cycle.
- Inputs are ignored while `in_ready`=0.

## Timing
- Reset values: state=IDLE, `in_ready`=1, `out_valid`=0, `out_result`=0, and all datapath registers are 0.
- Reset asserted mid-CALC or mid-DONE aborts the operation immediately; no result is produced.
- Accept in cycle N gives CALC in cycles N+1..N+32, with `out_valid` first high in cycle N+33.
- `out_result` is stable for as long as `out_valid`=1.
- Back-to-back throughput is one op per 34 cycles minimum.

## Configuration
- `MDU_DIV_EARLY_OUT_EN` defined:
  - special cases (b==0, signed overflow) go IDLE → DONE directly;
  - `out_valid` is high in cycle N+1.
- Undefined:
  - special cases run the full 32 steps and the special result overrides at DONE;
  - latency is always N+33.
- Results are identical either way.

## Structure
- `mdu_pkg` holds:
  - the `mdu_op_t` enum (DIV, DIVU, REM, REMU);
  - the `div_state_t` enum (IDLE, CALC, DONE);
  - the `DIV_CNT_W`=6 constant.
- Sub-module `div_step` is the combinational single restoring step:
  - inputs: rem[32:0], quo[31:0], divisor[31:0];
  - outputs: next rem and next quo.
- The top level holds the FSM, counter, operand preparation and sign fix-up.

## Test plan
- DIVU 100/7 → `out_result`=14 exactly in cycle N+33. REMU of the same operands → 2.
- DIV −7/2 → 0xFFFF_FFFD (−3). REM −7/2 → 0xFFFF_FFFF (−1). REM 7/−2 → 1.
- DIV 5/0 → 0xFFFF_FFFF; REM 5/0 → 5. With `MDU_DIV_EARLY_OUT_EN`, `out_valid` is high at N+1.
- DIV 0x8000_0000/0xFFFF_FFFF → 0x8000_0000; REM of the same operands → 0.
- Hold `out_ready`=0 for 10 cycles in DONE → `out_valid` and `out_result` stay stable. `in_valid` pulses during CALC are ignored, and `in_ready` returns 1 the cycle after `out_ready`.
- Assert `flush` at CALC step 15 → IDLE next cycle and `out_valid` never asserts. Assert `rst_n`=0 mid-op → all outputs return to reset values asynchronously.
